uart_cmd_parser: RTL and testbench

- Sits between the UART receiver and the display/LED logic. Consumes received bytes, one strobe per byte.
- Decodes two-byte command frames of the form opcode then payload. Updates the LED toggle, the display value and the max value.
- Flags malformed or timed-out frames.
- Returns a one-byte acknowledge to the UART transmitter through a valid/ready handshake.

---
 rtl/uart_cmd_pkg.sv | 37 +++
 rtl/uart_cmd_parser_if.sv | 28 ++
 rtl/cmd_timeout_timer.sv | 27 ++
 rtl/uart_cmd_parser.sv | 200 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: FSM states,
// opcode bytes, acknowledge codes and the committed-command encoding.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        COMMIT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_LED = 2'd0,
        CMD_SEG = 2'd1,
        CMD_MAX = 2'd2
    } cmd_op_e;

    localparam logic [7:0] OP_LED      = 8'hFF;
    localparam logic [7:0] OP_SEG      = 8'hFE;
    localparam logic [7:0] OP_MAX      = 8'hFD;
    localparam logic [7:0] ACK_OK_BASE = 8'hA0;
    localparam logic [7:0] ACK_ERR     = 8'hEE;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_LED) || (b == OP_SEG) || (b == OP_MAX);
    endfunction

    // Only meaningful for bytes that passed is_opcode().
    function automatic cmd_op_e decode_op(input logic [7:0] b);
        case (b)
            OP_LED:  return CMD_LED;
            OP_SEG:  return CMD_SEG;
            default: return CMD_MAX;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream, result and acknowledge signals of the command parser.
// slave is the parser's view; master is the surrounding UART/display logic.
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       led;
    logic [7:0] seg_val;
    logic [7:0] max_val;
    logic       over_max;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       err;
    logic       ack_valid;
    logic [7:0] ack_byte;
    logic       ack_ready;

    modport slave (
        input  rx_data, rx_done, ack_ready,
        output led, seg_val, max_val, over_max, cmd_valid, cmd_op, err,
               ack_valid, ack_byte
    );

    modport master (
        output rx_data, rx_done, ack_ready,
        input  led, seg_val, max_val, over_max, cmd_valid, cmd_op, err,
               ack_valid, ack_byte
    );
endinterface

// File: rtl/cmd_timeout_timer.sv
// Inter-byte gap counter: cleared on demand, counts while enabled, and
// flags expiry in the cycle the count reaches TIMEOUT_CYCLES-1.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TO_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes opcode/payload frames from the UART byte stream into LED, display
// and max-value updates with a one-byte ack. CMD_CHECKSUM_EN adds an XOR check byte.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic               clk,
    input  logic               reset,
    uart_cmd_parser_if.slave   bus
);

    state_e     r_state;
    state_e     w_next;
    logic [7:0] r_op_byte;
    logic [7:0] r_payload;
    logic       r_led;
    logic [7:0] r_seg_val;
    logic [7:0] r_max_val;
    logic       r_over_max;
    logic       r_cmd_valid;
    cmd_op_e    r_cmd_op;
    logic       r_err;
    logic       r_err_pend;
    logic       r_ack_valid;
    logic [7:0] r_ack_byte;

    logic       w_timeout;
    logic       w_tmr_active;
    cmd_op_e    w_op;
    logic       w_idle_byte;
    logic       w_latch_op;
    logic       w_latch_pl;
    logic       w_led_tgl;
    logic       w_seg_ld;
    logic       w_max_ld;
    logic       w_cmd_ok;
    logic       w_err_raw;
    logic       w_stray;
    logic       w_busy;
    logic       w_err;
    logic       w_defer;
    logic       w_ack_load;
    logic [7:0] w_ack_val;

    assign w_tmr_active = (r_state == PAYLOAD) || (r_state == CHECK);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_tmr_active || bus.rx_done),
        .i_enable  (w_tmr_active && !bus.rx_done),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal gets a default before the case, so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_idle_byte = 1'b0;
        w_latch_op  = 1'b0;
        w_latch_pl  = 1'b0;
        w_led_tgl   = 1'b0;
        w_seg_ld    = 1'b0;
        w_max_ld    = 1'b0;
        w_cmd_ok    = 1'b0;
        w_err_raw   = 1'b0;
        w_stray     = 1'b0;
        w_op        = decode_op(r_op_byte);

        case (r_state)
            IDLE: w_idle_byte = bus.rx_done;
            PAYLOAD: begin
                if (bus.rx_done) begin
                    w_latch_pl = 1'b1;
`ifdef CMD_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = COMMIT;
`endif
                end else if (w_timeout) begin
                    w_err_raw = 1'b1;
                    w_next    = IDLE;
                end
            end
`ifdef CMD_CHECKSUM_EN
            CHECK: begin
                if (bus.rx_done) begin
                    if (bus.rx_data == (r_op_byte ^ r_payload)) begin
                        w_next = COMMIT;
                    end else begin
                        w_err_raw = 1'b1;
                        w_next    = IDLE;
                    end
                end else if (w_timeout) begin
                    w_err_raw = 1'b1;
                    w_next    = IDLE;
                end
            end
`endif
            COMMIT: begin
                w_next      = IDLE;
                w_idle_byte = bus.rx_done;
                case (w_op)
                    CMD_LED: begin
                        if (r_payload == 8'h01) begin
                            w_led_tgl = 1'b1;
                            w_cmd_ok  = 1'b1;
                        end else begin
                            w_err_raw = 1'b1;
                        end
                    end
                    CMD_SEG: begin
                        w_seg_ld = 1'b1;
                        w_cmd_ok = 1'b1;
                    end
                    default: begin
                        w_max_ld = 1'b1;
                        w_cmd_ok = 1'b1;
                    end
                endcase
            end
            default: w_next = IDLE;
        endcase

        // A byte seen in IDLE or in the COMMIT cycle starts a new frame or is rejected.
        if (w_idle_byte) begin
            if (is_opcode(bus.rx_data)) begin
                w_latch_op = 1'b1;
                w_next     = PAYLOAD;
            end else begin
                w_stray = 1'b1;
            end
        end

        // A rejected byte in a cycle already owning a result is reported one cycle
        // later, so err/cmd_valid stay exclusive and no error pulse is merged away.
        w_busy     = (r_state == COMMIT) || r_err_pend;
        w_err      = w_err_raw || r_err_pend || (w_stray && !w_busy);
        w_defer    = w_stray && w_busy;
        w_ack_load = w_cmd_ok || w_err;
        w_ack_val  = w_cmd_ok ? (ACK_OK_BASE + 8'(w_op)) : ACK_ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_byte   <= '0;
            r_payload   <= '0;
            r_led       <= 1'b0;
            r_seg_val   <= '0;
            r_max_val   <= '0;
            r_over_max  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= CMD_LED;
            r_err       <= 1'b0;
            r_err_pend  <= 1'b0;
            r_ack_valid <= 1'b0;
            r_ack_byte  <= '0;
        end else begin
            r_cmd_valid <= w_cmd_ok;
            r_err       <= w_err;
            r_err_pend  <= w_defer;
            r_over_max  <= (r_seg_val > r_max_val);
            if (w_latch_op) r_op_byte <= bus.rx_data;
            if (w_latch_pl) r_payload <= bus.rx_data;
            if (w_led_tgl)  r_led     <= ~r_led;
            if (w_seg_ld)   r_seg_val <= r_payload;
            if (w_max_ld)   r_max_val <= r_payload;
            if (w_cmd_ok)   r_cmd_op  <= w_op;
            if (w_ack_load) begin
                r_ack_valid <= 1'b1;
                r_ack_byte  <= w_ack_val;
            end else if (r_ack_valid && bus.ack_ready) begin
                r_ack_valid <= 1'b0;
            end
        end
    end

    assign bus.led       = r_led;
    assign bus.seg_val   = r_seg_val;
    assign bus.max_val   = r_max_val;
    assign bus.over_max  = r_over_max;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_op    = r_cmd_op;
    assign bus.err       = r_err;
    assign bus.ack_valid = r_ack_valid;
    assign bus.ack_byte  = r_ack_byte;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed vector table, corner-case
// sequences and random frames against a frame-level reference model.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int TO = 16;
    localparam int TW = 5;
`ifdef CMD_CHECKSUM_EN
    localparam int FLEN = 3;
`else
    localparam int FLEN = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(.TIMEOUT_CYCLES(TO), .TO_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    int         err_cnt = 0;
    int         ok_cnt  = 0;
    logic [7:0] got_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.err) err_cnt++;
            if (bus.cmd_valid) ok_cnt++;
            if (bus.err || bus.cmd_valid) check("err_cmd_exclusive", 32'(bus.err & bus.cmd_valid), 0);
            if (prev_valid && !prev_ready) begin
                check("ack_valid_hold", 32'(bus.ack_valid), 1);
                if (!(bus.err || bus.cmd_valid)) check("ack_byte_hold", 32'(bus.ack_byte), 32'(prev_byte));
            end
            if (bus.ack_valid && bus.ack_ready) got_q.push_back(bus.ack_byte);
            prev_valid = bus.ack_valid;
            prev_ready = bus.ack_ready;
            prev_byte  = bus.ack_byte;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- frame-level reference model ----------------
    logic       m_led;
    logic [7:0] m_seg, m_max;
    logic [1:0] m_op;
    int         m_err, m_ok;
    logic [7:0] m_q[$];
    logic [7:0] m_frame[$];

    function automatic bit is_op(input logic [7:0] b);
        return b == 8'hFF || b == 8'hFE || b == 8'hFD;
    endfunction

    task automatic model_reset();
        m_led = 0; m_seg = 0; m_max = 0; m_op = 0; m_err = 0; m_ok = 0;
        m_q.delete(); m_frame.delete();
    endtask

    task automatic model_error();
        m_err++;
        m_q.push_back(8'hEE);
    endtask

    task automatic model_frame();
        logic [7:0] op, pl;
        logic [1:0] code;
        bit ok;
        op = m_frame[0];
        pl = m_frame[1];
        ok = 1;
        code = (op == 8'hFF) ? 2'd0 : (op == 8'hFE) ? 2'd1 : 2'd2;
`ifdef CMD_CHECKSUM_EN
        if (m_frame[2] != (op ^ pl)) ok = 0;
`endif
        if (ok) begin
            if (code == 2'd0) begin
                if (pl == 8'h01) m_led = !m_led; else ok = 0;
            end else if (code == 2'd1) m_seg = pl;
            else m_max = pl;
        end
        if (ok) begin
            m_op = code;
            m_ok++;
            m_q.push_back(8'hA0 + 8'(code));
        end else begin
            model_error();
        end
        m_frame.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_frame.size() == 0 && !is_op(b)) begin
            model_error();
        end else begin
            m_frame.push_back(b);
            if (m_frame.size() == FLEN) model_frame();
        end
    endtask

    task automatic model_timeout();
        if (m_frame.size() != 0) begin
            model_error();
            m_frame.delete();
        end
    endtask

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        model_byte(b);
        @(posedge clk); #1;
        bus.rx_done = 1'b0;
        idle(gap);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] pl,
                              input logic [7:0] chk, input int g, input int g_last);
`ifdef CMD_CHECKSUM_EN
        send_byte(op, g);
        send_byte(pl, g);
        send_byte(chk, g_last);
`else
        send_byte(op, g);
        send_byte(pl, g_last);
`endif
    endtask

    task automatic gap_timeout();
        idle(TO + 2);
        model_timeout();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_seg"},      32'(bus.seg_val),  32'(m_seg));
        check({tag, "_max"},      32'(bus.max_val),  32'(m_max));
        check({tag, "_led"},      32'(bus.led),      32'(m_led));
        check({tag, "_over"},     32'(bus.over_max), 32'(m_seg > m_max));
        check({tag, "_op"},       32'(bus.cmd_op),   32'(m_op));
        check({tag, "_err_cnt"},  32'(err_cnt),      32'(m_err));
        check({tag, "_ok_cnt"},   32'(ok_cnt),       32'(m_ok));
    endtask

    task automatic check_acks(input string tag);
        int n;
        check({tag, "_ack_count"}, 32'(got_q.size()), 32'(m_q.size()));
        n = (got_q.size() < m_q.size()) ? got_q.size() : m_q.size();
        for (int i = 0; i < n; i++) check({tag, "_ack_seq"}, 32'(got_q[i]), 32'(m_q[i]));
        got_q.delete();
        m_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led"},   32'(bus.led), 0);
        check({tag, "_seg"},   32'(bus.seg_val), 0);
        check({tag, "_max"},   32'(bus.max_val), 0);
        check({tag, "_over"},  32'(bus.over_max), 0);
        check({tag, "_op"},    32'(bus.cmd_op), 0);
        check({tag, "_cv"},    32'(bus.cmd_valid), 0);
        check({tag, "_err"},   32'(bus.err), 0);
        check({tag, "_ackv"},  32'(bus.ack_valid), 0);
        check({tag, "_ackb"},  32'(bus.ack_byte), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        check_all_zero("reset");
        reset = 1'b0;
        model_reset();
        err_cnt = 0;
        ok_cnt  = 0;
        got_q.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] op, pl, chk;
        logic       exp_led;
        logic [7:0] exp_seg, exp_max;
        logic       exp_over;
        logic [1:0] exp_op;
        logic [7:0] exp_ack;
        logic       exp_err;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] ops[3];
    logic [7:0] r_op, r_pl, r_chk;

    initial begin
        int e0, o0, k;
        bit seen;

        reset       = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.ack_ready = 1'b1;
        ops = '{8'hFF, 8'hFE, 8'hFD};
        model_reset();
        @(posedge clk); #1;
        do_reset();

        vecs.push_back('{8'hFE, 8'h7B, 8'h85, 1'b0, 8'h7B, 8'h00, 1'b1, 2'd1, 8'hA1, 1'b0});
        vecs.push_back('{8'hFD, 8'h64, 8'h99, 1'b0, 8'h7B, 8'h64, 1'b1, 2'd2, 8'hA2, 1'b0});
        vecs.push_back('{8'hFE, 8'h65, 8'h9B, 1'b0, 8'h65, 8'h64, 1'b1, 2'd1, 8'hA1, 1'b0});
        vecs.push_back('{8'hFE, 8'h64, 8'h9A, 1'b0, 8'h64, 8'h64, 1'b0, 2'd1, 8'hA1, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 8'hFE, 1'b1, 8'h64, 8'h64, 1'b0, 2'd0, 8'hA0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 8'hFE, 1'b0, 8'h64, 8'h64, 1'b0, 2'd0, 8'hA0, 1'b0});
        vecs.push_back('{8'hFF, 8'h02, 8'hFD, 1'b0, 8'h64, 8'h64, 1'b0, 2'd0, 8'hEE, 1'b1});
        vecs.push_back('{8'hFD, 8'h00, 8'hFD, 1'b0, 8'h64, 8'h00, 1'b1, 2'd2, 8'hA2, 1'b0});
`ifdef CMD_CHECKSUM_EN
        vecs.push_back('{8'hFE, 8'h10, 8'hEE, 1'b0, 8'h10, 8'h00, 1'b1, 2'd1, 8'hA1, 1'b0});
        vecs.push_back('{8'hFE, 8'h10, 8'h00, 1'b0, 8'h10, 8'h00, 1'b1, 2'd1, 8'hEE, 1'b1});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            e0 = err_cnt;
            o0 = ok_cnt;
            send_frame(vecs[i].op, vecs[i].pl, vecs[i].chk, 1, 1);
            idle(4);
            check("vec_led",  32'(bus.led),      32'(vecs[i].exp_led));
            check("vec_seg",  32'(bus.seg_val),  32'(vecs[i].exp_seg));
            check("vec_max",  32'(bus.max_val),  32'(vecs[i].exp_max));
            check("vec_over", 32'(bus.over_max), 32'(vecs[i].exp_over));
            check("vec_op",   32'(bus.cmd_op),   32'(vecs[i].exp_op));
            check("vec_err",  32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check("vec_ok",   32'(ok_cnt - o0),  32'(!vecs[i].exp_err));
            check("vec_ack",  32'(got_q.size() > 0 ? got_q[got_q.size()-1] : 8'h00), 32'(vecs[i].exp_ack));
        end
        check_state("table");
        check_acks("table");

        // ack_valid drops the cycle after a transfer with ack_ready=1
        send_frame(8'hFE, 8'h11, 8'hEF, 1, 0);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.cmd_valid) seen = 1; else idle(1);
        end
        check("cv_seen", 32'(seen), 1);
        check("cv_ackv", 32'(bus.ack_valid), 1);
        check("cv_ackb", 32'(bus.ack_byte), 32'h A1);
        idle(1);
        check("cv_ack_drop", 32'(bus.ack_valid), 0);
        idle(3);
        check_state("ackdrop");

        // timeout: opcode then silence -> err after TO cycles
        send_byte(8'hFE, 0);
        k = 0;
        for (int c = 1; c <= 3 * TO && k == 0; c++) begin
            idle(1);
            if (bus.err) k = c;
        end
        check("timeout_cycles", 32'(k), 32'(TO));
        model_timeout();
        idle(4);
        send_byte(8'h33, 4);
        check_state("timeout");
        // one cycle short of the limit still completes the frame
        send_byte(8'hFE, TO - 1);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h42, TO - 1);
        send_byte(8'hFE ^ 8'h42, 4);
`else
        send_byte(8'h42, 4);
`endif
        check_state("boundary");
        check_acks("timeout");

        // bytes arriving during the commit cycle: stray, then opcode
        send_frame(8'hFE, 8'h55, 8'hAB, 1, 0);
        send_byte(8'h33, 0);
        send_frame(8'hFD, 8'h50, 8'hAD, 0, 0);
        send_frame(8'hFE, 8'h60, 8'h9E, 1, 4);
        check_state("commit_byte");
        check_acks("commit_byte");

        // back-to-back results with ack_ready low: latest one is held
        bus.ack_ready = 1'b0;
        send_frame(8'hFD, 8'h20, 8'hDD, 1, 0);
        send_frame(8'hFE, 8'h21, 8'hDF, 0, 4);
        check("hold_ackv", 32'(bus.ack_valid), 1);
        check("hold_ackb", 32'(bus.ack_byte), 32'h A1);
        bus.ack_ready = 1'b1;
        idle(1);
        check("hold_release", 32'(bus.ack_valid), 0);
        check_state("hold");
        got_q.delete();
        m_q.delete();

        // reset in the middle of a frame
        send_byte(8'hFE, 2);
        do_reset();
        send_frame(8'hFE, 8'h12, 8'hEC, 1, 4);
        check_state("post_reset");
        check_acks("post_reset");

        // random frames against the reference model
        for (int it = 0; it < 150; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                send_byte(8'($urandom_range(0, 252)), $urandom_range(0, 3));
            end else if (sel == 1) begin
                send_byte(ops[$urandom_range(0, 2)], 0);
                gap_timeout();
            end else begin
                r_op = ops[$urandom_range(0, 2)];
                r_pl = (r_op == 8'hFF && $urandom_range(0, 1) == 1) ? 8'h01 : 8'($urandom_range(0, 255));
                r_chk = r_op ^ r_pl;
                if ($urandom_range(0, 7) == 0) r_chk = r_chk ^ (8'h01 << $urandom_range(0, 7));
                send_frame(r_op, r_pl, r_chk, $urandom_range(0, 3), $urandom_range(0, 2));
            end
            if (it % 10 == 9) begin
                idle(4);
                check_state("rand");
            end
        end
        idle(4);
        check_state("rand_end");
        check_acks("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
